// File: rtl/bomb_scheduler_pkg.sv
// Shared types and default sizing for the bomb scheduler slice.
// Slot and scheduler state encodings live here so the bench can see them.
package bomb_scheduler_pkg;

   localparam int DEF_NUM_ROW    = 11;
   localparam int DEF_NUM_COL    = 19;
   localparam int DEF_NUM_SLOTS  = 4;
   localparam int DEF_FUSE_TICKS = 180;
   localparam int DEF_ADDR_W     = $clog2(DEF_NUM_ROW * DEF_NUM_COL);
   localparam int DEF_FUSE_W     = $clog2(DEF_FUSE_TICKS + 1);

   // cycles WAIT_START tolerates without busy before giving up on the trigger
   localparam int LOST_TRIG_CYCLES = 4;

   typedef enum logic [1:0] {
      SCH_IDLE,
      SCH_FIRE,
      SCH_WAIT_START,
      SCH_WAIT_DONE
   } bomb_sched_state_t;

   typedef enum logic [1:0] {
      SLOT_FREE,
      SLOT_ARMED,
      SLOT_PENDING
   } bomb_slot_state_t;

endpackage

// File: rtl/bomb_scheduler_if.sv
// Placement, explosion-trigger and occupancy-query signals of the scheduler.
// master = game side / explosion unit, slave = bomb_scheduler.
interface bomb_scheduler_if
   import bomb_scheduler_pkg::*;
#(
   parameter int AW = DEF_ADDR_W,
   parameter int NS = DEF_NUM_SLOTS
);

   logic          place_req;
   logic [AW-1:0] place_addr;
   logic          place_ack;
   logic          place_nack;
   logic          explode_busy;
   logic          trigger_explosion;
   logic [AW-1:0] explosion_addr;
   logic [AW-1:0] query_addr;
   logic          query_hit;
   logic [NS-1:0] slot_valid;

   modport master (
      output place_req,
      output place_addr,
      output explode_busy,
      output query_addr,
      input  place_ack,
      input  place_nack,
      input  trigger_explosion,
      input  explosion_addr,
      input  query_hit,
      input  slot_valid
   );

   modport slave (
      input  place_req,
      input  place_addr,
      input  explode_busy,
      input  query_addr,
      output place_ack,
      output place_nack,
      output trigger_explosion,
      output explosion_addr,
      output query_hit,
      output slot_valid
   );

endinterface

// File: rtl/bomb_scheduler_rr_arbiter.sv
// Round-robin arbiter: first request at or after ptr_i wins, one-hot grant.
module rr_arbiter #(
   parameter  int N  = 4,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [PW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic          valid_o
);

   logic          found;
   logic [PW-1:0] idx;

   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         idx = PW'((int'(ptr_i) + k) % N);
         if (!found && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            found      = 1'b1;
         end
      end
      valid_o = |req_i;
   end

endmodule

// File: rtl/bomb_scheduler.sv
// Bomb slot owner: placement, per-slot fuses, and one-at-a-time
// serialisation of expired bombs onto the explosion unit.
module bomb_scheduler
   import bomb_scheduler_pkg::*;
#(
   parameter int NUM_ROW    = DEF_NUM_ROW,
   parameter int NUM_COL    = DEF_NUM_COL,
   parameter int NUM_SLOTS  = DEF_NUM_SLOTS,
   parameter int FUSE_TICKS = DEF_FUSE_TICKS
) (
   input logic       clk,
   input logic       rst,
   input logic       tick_i,
   input logic       game_over_i,
   bomb_scheduler_if.slave bus
);

   localparam int AW = $clog2(NUM_ROW * NUM_COL);
   localparam int FW = $clog2(FUSE_TICKS + 1);
   localparam int PW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
   localparam logic [FW-1:0] FUSE_LOAD = FW'(FUSE_TICKS);
   localparam logic [2:0] WAIT_LAST = 3'(LOST_TRIG_CYCLES - 1);

   logic clr;
   assign clr = rst | game_over_i;

   bomb_slot_state_t st_q   [NUM_SLOTS];
   bomb_slot_state_t st_d   [NUM_SLOTS];
   logic [AW-1:0]    addr_q [NUM_SLOTS];
   logic [AW-1:0]    addr_d [NUM_SLOTS];
   logic [FW-1:0]    fuse_q [NUM_SLOTS];
   logic [FW-1:0]    fuse_d [NUM_SLOTS];

   bomb_sched_state_t fsm_q;
   logic [PW-1:0]     rr_q;
   logic [PW-1:0]     win_q;
   logic [AW-1:0]     exp_addr_q;
   logic              trig_q;
   logic [2:0]        wait_q;
   logic              ack_q;
   logic              nack_q;

   logic [NUM_SLOTS-1:0] occ;
   logic [NUM_SLOTS-1:0] pend;
   logic [NUM_SLOTS-1:0] free_v;
   logic [NUM_SLOTS-1:0] dup;
   logic [NUM_SLOTS-1:0] qhit;
   logic [PW-1:0]        free_idx;
   logic                 accept;

   always_comb begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
         occ[i]    = st_q[i] != SLOT_FREE;
         pend[i]   = st_q[i] == SLOT_PENDING;
         free_v[i] = st_q[i] == SLOT_FREE;
         dup[i]    = occ[i] && (addr_q[i] == bus.place_addr);
         qhit[i]   = occ[i] && (addr_q[i] == bus.query_addr);
      end
   end

   always_comb begin
      free_idx = '0;
      for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
         if (free_v[i]) free_idx = PW'(i);
      end
   end

   // the slot being fired is still PENDING here, so it cannot be reused yet
   assign accept = bus.place_req && (|free_v) && !(|dup);

   logic [NUM_SLOTS-1:0] gnt;
   logic                 gnt_vld;
   logic [PW-1:0]        gnt_idx;

   rr_arbiter #(.N(NUM_SLOTS)) u_arb (
      .req_i   (pend),
      .ptr_i   (rr_q),
      .gnt_o   (gnt),
      .valid_o (gnt_vld)
   );

   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (gnt[i]) gnt_idx = gnt_idx | PW'(i);
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
         st_d[i]   = st_q[i];
         addr_d[i] = addr_q[i];
         fuse_d[i] = fuse_q[i];
         if (tick_i && st_q[i] == SLOT_ARMED && fuse_q[i] != '0) begin
            fuse_d[i] = fuse_q[i] - 1'b1;
            if (fuse_q[i] == FW'(1)) st_d[i] = SLOT_PENDING;
         end
         if (fsm_q == SCH_FIRE && win_q == PW'(i)) st_d[i] = SLOT_FREE;
         if (accept && free_idx == PW'(i)) begin
            st_d[i]   = SLOT_ARMED;
            addr_d[i] = bus.place_addr;
            fuse_d[i] = FUSE_LOAD;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            st_q[i]   <= SLOT_FREE;
            addr_q[i] <= '0;
            fuse_q[i] <= '0;
         end
         ack_q  <= 1'b0;
         nack_q <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            st_q[i]   <= st_d[i];
            addr_q[i] <= addr_d[i];
            fuse_q[i] <= fuse_d[i];
         end
         ack_q  <= accept;
         nack_q <= bus.place_req && !accept;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         fsm_q      <= SCH_IDLE;
         rr_q       <= '0;
         win_q      <= '0;
         exp_addr_q <= '0;
         trig_q     <= 1'b0;
         wait_q     <= '0;
      end else begin
         trig_q <= 1'b0;
         unique case (fsm_q)
            SCH_IDLE: begin
               if (gnt_vld && !bus.explode_busy) begin
                  fsm_q      <= SCH_FIRE;
                  win_q      <= gnt_idx;
                  exp_addr_q <= addr_q[gnt_idx];
                  trig_q     <= 1'b1;
               end
            end
            SCH_FIRE: begin
               rr_q   <= (win_q == PW'(NUM_SLOTS - 1)) ? '0 : win_q + 1'b1;
               wait_q <= '0;
               fsm_q  <= SCH_WAIT_START;
            end
            SCH_WAIT_START: begin
               if (bus.explode_busy) fsm_q <= SCH_WAIT_DONE;
               else if (wait_q == WAIT_LAST) fsm_q <= SCH_IDLE;
               else wait_q <= wait_q + 1'b1;
            end
            SCH_WAIT_DONE: begin
               if (!bus.explode_busy) fsm_q <= SCH_IDLE;
            end
            default: fsm_q <= SCH_IDLE;
         endcase
      end
   end

   assign bus.place_ack         = ack_q;
   assign bus.place_nack        = nack_q;
   assign bus.trigger_explosion = trig_q;
   assign bus.explosion_addr    = exp_addr_q;
   assign bus.query_hit         = |qhit;
   assign bus.slot_valid        = occ;

endmodule

// File: tb/tb_bomb_scheduler.sv
// Bench for bomb_scheduler: placement vector table plus fuse/arbitration
// sequences, with a scoreboard of expected explosion addresses.
module tb_bomb_scheduler;
   import bomb_scheduler_pkg::*;

   localparam int AW = DEF_ADDR_W;
   localparam int BUSY_LEN = 61;

   logic clk = 1'b0;
   logic rst;
   logic tick;
   logic game_over;
   logic mdl_busy;
   logic frc_busy;
   logic mdl_en;

   int nvec = 0;
   int nerr = 0;
   int cyc_n = 0;
   int n_trig = 0;
   int trig_t[$];
   logic [AW-1:0] sb[$];

   bomb_scheduler_if bif ();
   assign bif.explode_busy = mdl_busy | frc_busy;

   bomb_scheduler dut (
      .clk         (clk),
      .rst         (rst),
      .tick_i      (tick),
      .game_over_i (game_over),
      .bus         (bif)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n <= cyc_n + 1;

   typedef struct {
      logic [AW-1:0] addr;
      logic [AW-1:0] qaddr;
      logic          ack;
      logic          nack;
      logic [3:0]    valid;
      logic          hit;
   } vec_t;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_once();
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
   endtask

   task automatic place(input logic [AW-1:0] a);
      bif.place_req  = 1'b1;
      bif.place_addr = a;
      cyc();
      bif.place_req  = 1'b0;
   endtask

   task automatic wait_trig(input int target, input int lim);
      int k;
      k = 0;
      while (n_trig < target && k < lim) begin
         cyc();
         k++;
      end
      chk("trigger_timeout", 32'(n_trig), 32'(target));
   endtask

   // monitor: every trigger pulse is popped against the scoreboard
   initial begin : mon
      logic [AW-1:0] e;
      forever begin
         @(negedge clk);
         if (bif.trigger_explosion === 1'b1) begin
            n_trig++;
            trig_t.push_back(cyc_n);
            chk("trig_while_busy", 32'(bif.explode_busy), 32'd0);
            if (sb.size() == 0) begin
               nvec++;
               nerr++;
               $display("FAIL unexpected_trigger: addr %0d, none queued",
                        bif.explosion_addr);
            end else begin
               e = sb.pop_front();
               chk("explosion_addr", 32'(bif.explosion_addr), 32'(e));
            end
         end
      end
   end

   // explosion unit model: busy for BUSY_LEN cycles after each trigger
   initial begin : busy_model
      mdl_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (mdl_en && bif.trigger_explosion === 1'b1) begin
            #1 mdl_busy = 1'b1;
            repeat (BUSY_LEN) @(negedge clk);
            #1 mdl_busy = 1'b0;
         end
      end
   end

   initial begin : stim
      vec_t tbl[6];
      tbl[0] = '{8'd40, 8'd40, 1'b1, 1'b0, 4'h1, 1'b1};
      tbl[1] = '{8'd41, 8'd40, 1'b1, 1'b0, 4'h3, 1'b1};
      tbl[2] = '{8'd40, 8'd41, 1'b0, 1'b1, 4'h3, 1'b1};
      tbl[3] = '{8'd42, 8'd99, 1'b1, 1'b0, 4'h7, 1'b0};
      tbl[4] = '{8'd43, 8'd43, 1'b1, 1'b0, 4'hF, 1'b1};
      tbl[5] = '{8'd44, 8'd44, 1'b0, 1'b1, 4'hF, 1'b0};

      rst            = 1'b1;
      tick           = 1'b0;
      game_over      = 1'b0;
      frc_busy       = 1'b0;
      mdl_en         = 1'b1;
      bif.place_req  = 1'b0;
      bif.place_addr = '0;
      bif.query_addr = '0;
      repeat (3) cyc();

      chk("rst_ack", 32'(bif.place_ack), 32'd0);
      chk("rst_nack", 32'(bif.place_nack), 32'd0);
      chk("rst_trig", 32'(bif.trigger_explosion), 32'd0);
      chk("rst_eaddr", 32'(bif.explosion_addr), 32'd0);
      chk("rst_valid", 32'(bif.slot_valid), 32'd0);
      chk("rst_hit", 32'(bif.query_hit), 32'd0);
      rst = 1'b0;
      cyc();

      for (int i = 0; i < 6; i++) begin
         bif.query_addr = tbl[i].qaddr;
         if (tbl[i].ack) sb.push_back(tbl[i].addr);
         place(tbl[i].addr);
         chk($sformatf("v%0d_ack", i), 32'(bif.place_ack), 32'(tbl[i].ack));
         chk($sformatf("v%0d_nack", i), 32'(bif.place_nack),
             32'(tbl[i].nack));
         chk($sformatf("v%0d_valid", i), 32'(bif.slot_valid),
             32'(tbl[i].valid));
         chk($sformatf("v%0d_hit", i), 32'(bif.query_hit), 32'(tbl[i].hit));
      end
      cyc();
      chk("ack_one_cycle", 32'(bif.place_ack | bif.place_nack), 32'd0);

      // all four expire on the same tick; rr from slot 0, busy between
      bif.query_addr = 8'd40;
      repeat (179) tick_once();
      chk("no_early_trig", 32'(n_trig), 32'd0);
      chk("armed_at_179", 32'(bif.slot_valid), 32'hF);
      tick_once();
      wait_trig(4, 1000);
      chk("all_fired_valid", 32'(bif.slot_valid), 32'd0);
      chk("fired_hit40", 32'(bif.query_hit), 32'd0);
      chk("busy_gap", 32'(trig_t[1] - trig_t[0]), 32'(BUSY_LEN + 2));
      chk("sb_empty_a", 32'(sb.size()), 32'd0);
      repeat (70) cyc();

      // explosion unit never answers: lost-trigger guard releases the FSM
      mdl_en = 1'b0;
      sb.push_back(8'd50);
      place(8'd50);
      chk("p50_ack", 32'(bif.place_ack), 32'd1);
      sb.push_back(8'd51);
      place(8'd51);
      chk("p51_ack", 32'(bif.place_ack), 32'd1);
      repeat (180) tick_once();
      wait_trig(6, 200);
      chk("lost_gap", 32'(trig_t[5] - trig_t[4]), 32'd6);
      repeat (3) cyc();

      // game_over with three armed bombs and a busy unit
      frc_busy = 1'b1;
      place(8'd60);
      place(8'd61);
      place(8'd62);
      chk("p62_ack", 32'(bif.place_ack), 32'd1);
      chk("go_pre_valid", 32'(bif.slot_valid), 32'h7);
      bif.query_addr = 8'd60;
      game_over = 1'b1;
      cyc();
      game_over = 1'b0;
      chk("go_valid", 32'(bif.slot_valid), 32'd0);
      chk("go_ack", 32'(bif.place_ack), 32'd0);
      chk("go_trig", 32'(bif.trigger_explosion), 32'd0);
      chk("go_eaddr", 32'(bif.explosion_addr), 32'd0);
      chk("go_hit", 32'(bif.query_hit), 32'd0);
      frc_busy = 1'b0;
      mdl_en = 1'b1;
      cyc();

      // tick coincident with placement keeps the full fuse
      bif.query_addr = 8'd70;
      sb.push_back(8'd70);
      tick = 1'b1;
      place(8'd70);
      tick = 1'b0;
      chk("p70_ack", 32'(bif.place_ack), 32'd1);
      chk("p70_hit", 32'(bif.query_hit), 32'd1);
      cyc();
      repeat (179) tick_once();
      chk("p70_no_early", 32'(n_trig), 32'd6);
      chk("p70_valid", 32'(bif.slot_valid), 32'd1);
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
      chk("p70_trig", 32'(bif.trigger_explosion), 32'd1);
      chk("p70_eaddr", 32'(bif.explosion_addr), 32'd70);

      // place to the tile being fired, in the fire cycle
      place(8'd70);
      chk("fire_cyc_nack", 32'(bif.place_nack), 32'd1);
      chk("fire_cyc_ack", 32'(bif.place_ack), 32'd0);
      chk("fired_hit70", 32'(bif.query_hit), 32'd0);
      place(8'd70);
      chk("replace_ack", 32'(bif.place_ack), 32'd1);
      chk("replace_hit", 32'(bif.query_hit), 32'd1);
      repeat (3) cyc();
      chk("total_trigs", 32'(n_trig), 32'd7);
      chk("sb_empty_end", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
